seq_memory_game: RTL

//  Parametrised single-module successor of the 4-key memory game. Generates a pseudo-random

---
 rtl/seq_memory_game.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/seq_memory_game.sv
// ----------------------------------------------------------------------------
// seq_memory_game: LFSR-driven memory game: generate, show, collect, check.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_memory_game #(
  parameter int          NUM_KEYS   = 4,
  parameter int          SEQ_LEN    = 7,
  parameter int          MAX_LIVES  = 3,
  parameter int          NUM_LEVELS = 5,
  parameter int          SHOW_BASE  = 16,
  parameter int          SHOW_STEP  = 2,
  parameter int          SHOW_MIN   = 4,
  parameter int          BLANK_CYC  = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  localparam int         KW  = ($clog2(NUM_KEYS) > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int         LW  = $clog2(NUM_LEVELS + 1),
  localparam int         LVW = $clog2(MAX_LIVES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                start,
  input  logic                show_again,
  input  logic                restart,
  output logic                show_valid,
  output logic [KW-1:0]       show_sym,
  output logic                clear,
  output logic                ready,
  output logic [LW-1:0]       level,
  output logic [LVW-1:0]      lives,
  output logic                victory,
  output logic                game_over
);

  localparam int IW    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int TMAX0 = (SHOW_BASE > SHOW_MIN) ? SHOW_BASE : SHOW_MIN;
  localparam int TMAX  = (TMAX0 > BLANK_CYC) ? TMAX0 : BLANK_CYC;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_SHOW, S_BLANK, S_INPUT, S_CHECK, S_VICTORY, S_OVER
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic [KW-1:0]       seq_q [SEQ_LEN];
  logic [KW-1:0]       seq_d [SEQ_LEN];
  logic [KW-1:0]       in_q  [SEQ_LEN];
  logic [KW-1:0]       in_d  [SEQ_LEN];
  logic [IW-1:0]       idx_q, idx_d, cnt_q, cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [LW-1:0]       level_q, level_d;
  logic [LVW-1:0]      lives_q, lives_d;
  logic                credit_q, credit_d;
  logic                show_valid_q, show_valid_d, clear_q, clear_d, ready_q, ready_d;
  logic                victory_q, victory_d, game_over_q, game_over_d;
  logic [KW-1:0]       show_sym_q, show_sym_d;

  logic                lfsr_fb, press, match;
  logic [NUM_KEYS-1:0] rise;
  logic [KW-1:0]       press_sym, gen_sym;
  logic [TW-1:0]       show_last;
  int                  show_dec;

  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign gen_sym = KW'(32'(lfsr_q[KW-1:0]) % NUM_KEYS);

  // A press is a fresh edge on one key while every other key is released.
  assign rise  = keys & ~keys_q;
  assign press = $onehot(keys) && (rise == keys);

  always_comb begin
    press_sym = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (keys[k]) press_sym = KW'(k);
    end
  end

  always_comb begin
    match = 1'b1;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (in_q[i] != seq_q[i]) match = 1'b0;
    end
  end

  always_comb begin
    show_dec = (int'(level_q) - 1) * SHOW_STEP;
    if (SHOW_BASE - show_dec > SHOW_MIN) show_last = TW'(SHOW_BASE - show_dec - 1);
    else                                 show_last = TW'(SHOW_MIN - 1);
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = {lfsr_fb, lfsr_q[15:1]};
    keys_d   = keys;
    seq_d    = seq_q;
    in_d     = in_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    level_d  = level_q;
    lives_d  = lives_q;
    credit_d = credit_q;

    if (restart) begin
      state_d  = S_IDLE;
      keys_d   = '0;
      idx_d    = '0;
      cnt_d    = '0;
      timer_d  = '0;
      level_d  = LW'(1);
      lives_d  = LVW'(MAX_LIVES);
      credit_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_GEN;
            idx_d   = '0;
          end
        end
        S_GEN: begin
          seq_d[idx_d] = gen_sym;
          if (idx_q == IW'(SEQ_LEN - 1)) begin
            state_d = S_SHOW;
            idx_d   = '0;
            timer_d = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        S_SHOW: begin
          if (timer_q == show_last) begin
            state_d = S_BLANK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_BLANK: begin
          if (timer_q == TW'(BLANK_CYC - 1)) begin
            timer_d = '0;
            if (idx_q == IW'(SEQ_LEN - 1)) begin
              state_d = S_INPUT;
              cnt_d   = '0;
            end else begin
              state_d = S_SHOW;
              idx_d   = idx_q + IW'(1);
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_INPUT: begin
          // A granted replay request wins over a press in the same cycle.
          if (show_again && credit_q) begin
            credit_d = 1'b0;
            cnt_d    = '0;
            idx_d    = '0;
            timer_d  = '0;
            state_d  = S_SHOW;
          end else if (press) begin
            in_d[cnt_q] = press_sym;
            if (cnt_q == IW'(SEQ_LEN - 1)) begin
              state_d = S_CHECK;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + IW'(1);
            end
          end
        end
        S_CHECK: begin
          if (match) begin
            if (level_q == LW'(NUM_LEVELS)) begin
              state_d = S_VICTORY;
            end else begin
              level_d  = level_q + LW'(1);
              credit_d = 1'b1;
              idx_d    = '0;
              state_d  = S_GEN;
            end
          end else begin
            if (lives_q != '0) lives_d = lives_q - LVW'(1);
            if (lives_q <= LVW'(1)) begin
              state_d = S_OVER;
            end else begin
              cnt_d   = '0;
              state_d = S_INPUT;
            end
          end
        end
        S_VICTORY: state_d = S_VICTORY;
        S_OVER:    state_d = S_OVER;
        default:   state_d = S_IDLE;
      endcase
    end

    show_valid_d = (state_d == S_SHOW);
    show_sym_d   = show_valid_d ? seq_d[idx_d] : '0;
    clear_d      = (state_d == S_IDLE) || (state_d == S_BLANK) || (state_d == S_OVER);
    ready_d      = (state_d == S_INPUT);
    victory_d    = (state_d == S_VICTORY);
    game_over_d  = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      keys_q       <= '0;
      seq_q        <= '{default: '0};
      in_q         <= '{default: '0};
      idx_q        <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      level_q      <= LW'(1);
      lives_q      <= LVW'(MAX_LIVES);
      credit_q     <= 1'b1;
      show_valid_q <= 1'b0;
      show_sym_q   <= '0;
      clear_q      <= 1'b1;
      ready_q      <= 1'b0;
      victory_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      keys_q       <= keys_d;
      seq_q        <= seq_d;
      in_q         <= in_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      credit_q     <= credit_d;
      show_valid_q <= show_valid_d;
      show_sym_q   <= show_sym_d;
      clear_q      <= clear_d;
      ready_q      <= ready_d;
      victory_q    <= victory_d;
      game_over_q  <= game_over_d;
    end
  end

  assign show_valid = show_valid_q;
  assign show_sym   = show_sym_q;
  assign clear      = clear_q;
  assign ready      = ready_q;
  assign level      = level_q;
  assign lives      = lives_q;
  assign victory    = victory_q;
  assign game_over  = game_over_q;

endmodule

`default_nettype wire
